// File: rtl/rx_recovery_pkg.sv
// Shared RX recovery types: lock-engine states and 64b/66b sync-header constants.
package rx_recovery_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FORCED = 2'd2
  } lock_state_e;

  localparam logic [1:0] HDR_DATA        = 2'b01;
  localparam logic [1:0] HDR_CTRL        = 2'b10;
  localparam int         DEFAULT_BLOCK_W = 66;

  function automatic logic hdr_is_good(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/header_locker_hdr_mux.sv
// Selects the 2-bit sync header at a candidate block offset and flags it good/bad.
module hdr_mux
  import rx_recovery_pkg::*;
#(
  parameter int BUF_W    = 194,
  parameter int BLOCK_W  = DEFAULT_BLOCK_W,
  parameter int HDR_BASE = 0,
  parameter int OFF_W    = $clog2(BLOCK_W)
) (
  input  logic [BUF_W-1:0] buffer,
  input  logic [OFF_W-1:0] offset,
  output logic [1:0]       hdr,
  output logic             hdr_good
);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_W - 1);

  logic [1:0] hdr_at [BLOCK_W];
  logic       buf_unused;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_W; gi++) begin : g_hdr
      assign hdr_at[gi] = buffer[HDR_BASE+gi+1 : HDR_BASE+gi];
    end
  endgenerate

  // Out-of-range offsets read as an invalid header rather than aliasing.
  always_comb begin
    hdr = 2'b00;
    if (offset <= LAST_OFF) hdr = hdr_at[offset];
  end

  assign hdr_good   = hdr_is_good(hdr);
  // Bits outside the header span are payload for the block extractor.
  assign buf_unused = ^buffer;

endmodule

// File: rtl/header_locker.sv
// 64b/66b sync-header lock engine: searches block offsets, locks after a good run,
// monitors bad-header rate while locked, and supports a manual offset override.
module header_locker
  import rx_recovery_pkg::*;
#(
  parameter int BUF_W      = 194,
  parameter int BLOCK_W    = DEFAULT_BLOCK_W,
  parameter int HDR_BASE   = 0,
  parameter int LOCK_CNT   = 32,
  parameter int MON_WIN    = 64,
  parameter int UNLOCK_BAD = 16,
  parameter int OFF_W      = $clog2(BLOCK_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buffer_dv,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic             force_i,
  input  logic [OFF_W-1:0] force_offset_i,
  output logic [OFF_W-1:0] block_offset,
  output logic             locked_o,
  output logic             slip_o,
  output logic [15:0]      slip_cnt_o
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(MON_WIN + 1);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);

  localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(BLOCK_W - 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]  WIN_TGT  = WIN_W'(MON_WIN);
  localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(UNLOCK_BAD);

  generate
    if ((HDR_BASE + BLOCK_W > BUF_W - 1) || (LOCK_CNT < 1) ||
        (UNLOCK_BAD < 1) || (UNLOCK_BAD > MON_WIN)) begin : g_param_err
      $error("header_locker: illegal parameter combination");
    end
  endgenerate

  lock_state_e       state_reg, state_next;
  logic [OFF_W-1:0]  offset_reg, offset_next;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
  logic [BAD_W-1:0]  bad_cnt_reg, bad_cnt_next;
  logic              locked_reg, locked_next;
  logic              slip_reg, slip_next;
  logic [15:0]       slip_cnt_reg;

  logic              hdr_good;
  logic [1:0]        hdr_unused;
  logic [OFF_W-1:0]  offset_inc, force_clamped;
  logic [GOOD_W-1:0] good_inc;
  logic [WIN_W-1:0]  win_inc;
  logic [BAD_W-1:0]  bad_inc;

  hdr_mux #(
    .BUF_W   (BUF_W),
    .BLOCK_W (BLOCK_W),
    .HDR_BASE(HDR_BASE),
    .OFF_W   (OFF_W)
  ) u_hdr_mux (
    .buffer  (gbox_buffer),
    .offset  (offset_reg),
    .hdr     (hdr_unused),
    .hdr_good(hdr_good)
  );

  always_comb begin
    state_next    = state_reg;
    offset_next   = offset_reg;
    good_cnt_next = good_cnt_reg;
    win_cnt_next  = win_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    locked_next   = locked_reg;
    slip_next     = 1'b0;

    offset_inc    = (offset_reg == LAST_OFF) ? '0 : offset_reg + 1'b1;
    force_clamped = (force_offset_i > LAST_OFF) ? LAST_OFF : force_offset_i;
    good_inc      = ((state_reg == FORCED) ? '0 : good_cnt_reg) + 1'b1;
    win_inc       = win_cnt_reg + 1'b1;
    bad_inc       = bad_cnt_reg + BAD_W'(!hdr_good);

    if (force_i) begin
      state_next    = FORCED;
      offset_next   = force_clamped;
      good_cnt_next = '0;
      win_cnt_next  = '0;
      bad_cnt_next  = '0;
      locked_next   = 1'b1;
    end else begin
      unique case (state_reg)
        // Leaving FORCED resumes the search at the forced offset with a fresh run.
        SEARCH, FORCED: begin
          if (state_reg == FORCED) begin
            state_next    = SEARCH;
            good_cnt_next = '0;
            locked_next   = 1'b0;
          end
          if (buffer_dv) begin
            if (hdr_good) begin
              if (good_inc == GOOD_TGT) begin
                state_next    = LOCKED;
                good_cnt_next = '0;
                win_cnt_next  = '0;
                bad_cnt_next  = '0;
                locked_next   = 1'b1;
              end else begin
                good_cnt_next = good_inc;
              end
            end else begin
              good_cnt_next = '0;
              offset_next   = offset_inc;
              slip_next     = 1'b1;
            end
          end
        end
        // Unlock wins over window rollover when both land on the same block.
        LOCKED: begin
          if (buffer_dv) begin
            if (bad_inc == BAD_TGT) begin
              state_next    = SEARCH;
              offset_next   = offset_inc;
              slip_next     = 1'b1;
              good_cnt_next = '0;
              win_cnt_next  = '0;
              bad_cnt_next  = '0;
              locked_next   = 1'b0;
            end else if (win_inc == WIN_TGT) begin
              win_cnt_next = '0;
              bad_cnt_next = '0;
            end else begin
              win_cnt_next = win_inc;
              bad_cnt_next = bad_inc;
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= SEARCH;
      offset_reg   <= '0;
      good_cnt_reg <= '0;
      win_cnt_reg  <= '0;
      bad_cnt_reg  <= '0;
      locked_reg   <= 1'b0;
      slip_reg     <= 1'b0;
      slip_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      offset_reg   <= offset_next;
      good_cnt_reg <= good_cnt_next;
      win_cnt_reg  <= win_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      locked_reg   <= locked_next;
      slip_reg     <= slip_next;
      if (slip_next && (slip_cnt_reg != 16'hFFFF)) slip_cnt_reg <= slip_cnt_reg + 1'b1;
    end
  end

  assign block_offset = offset_reg;
  assign locked_o     = locked_reg;
  assign slip_o       = slip_reg;
  assign slip_cnt_o   = slip_cnt_reg;

endmodule
